// File: rtl/icache_fill_ctrl.sv
// Stage-1 tag/status array write sequencer: reset/flush sweep, line-refill
// install, and arbitration of lookup reads against those writes.
module icache_fill_ctrl #(
    parameter int unsigned SET_BITS_WIDTH = 4,
    parameter int unsigned NUM_WAYS       = 4,
    parameter int unsigned TAG_WIDTH      = 8,
    parameter int unsigned SA_BITS        = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [SET_BITS_WIDTH-1:0]        i_lk_set_addr,
    input  logic                             i_lk_valid,
    output logic                             o_lk_ready,
    input  logic [SET_BITS_WIDTH-1:0]        i_fill_set_addr,
    input  logic [$clog2(NUM_WAYS)-1:0]      i_fill_way,
    input  logic [TAG_WIDTH-1:0]             i_fill_tag,
    input  logic                             i_fill_valid,
    output logic                             o_fill_ready,
    output logic                             o_fill_done,
    input  logic                             i_flush,
    output logic                             o_busy,
    input  logic                             i_s1_ready,
    output logic [SET_BITS_WIDTH-1:0]        o_r_set_addr,
    output logic                             o_r_valid,
    output logic [SET_BITS_WIDTH-1:0]        o_w_ta_set_addr,
    output logic [NUM_WAYS*TAG_WIDTH-1:0]    o_w_ta_data,
    output logic [NUM_WAYS-1:0]              o_w_ta_mask,
    output logic                             o_w_ta_valid,
    output logic [SET_BITS_WIDTH-1:0]        o_w_sa_set_addr,
    output logic [NUM_WAYS*SA_BITS-1:0]      o_w_sa_data,
    output logic [NUM_WAYS-1:0]              o_w_sa_mask,
    output logic                             o_w_sa_valid
);

    localparam int unsigned WAY_BITS = $clog2(NUM_WAYS);
    localparam int unsigned TA_W     = NUM_WAYS * TAG_WIDTH;
    localparam int unsigned SA_W     = NUM_WAYS * SA_BITS;
    localparam logic [SET_BITS_WIDTH-1:0] LAST_SET = '1;

    typedef enum logic [1:0] {
        ST_SWEEP = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [SET_BITS_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
    logic                      flush_pend_q, flush_pend_d;
    logic                      fill_done_q;
    logic                      fill_accept;
    logic [SET_BITS_WIDTH-1:0] fill_set_q;
    logic [WAY_BITS-1:0]       fill_way_q;
    logic [TAG_WIDTH-1:0]      fill_tag_q;

    // State, sweep counter, pending flush and registered fill-done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SWEEP;
            sweep_cnt_q  <= '0;
            flush_pend_q <= 1'b0;
            fill_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_cnt_q  <= sweep_cnt_d;
            flush_pend_q <= flush_pend_d;
            fill_done_q  <= (state_q == ST_FILL) && i_s1_ready;
        end
    end

    // Refill request capture; only meaningful while in FILL, so no reset
    always_ff @(posedge clk) begin
        if (fill_accept) begin
            fill_set_q <= i_fill_set_addr;
            fill_way_q <= i_fill_way;
            fill_tag_q <= i_fill_tag;
        end
    end

    // Next-state and output decode; rst blanks every handshake and write
    always_comb begin
        state_d         = state_q;
        sweep_cnt_d     = sweep_cnt_q;
        flush_pend_d    = flush_pend_q;
        fill_accept     = 1'b0;
        o_lk_ready      = 1'b0;
        o_fill_ready    = 1'b0;
        o_r_valid       = 1'b0;
        o_r_set_addr    = '0;
        o_w_ta_valid    = 1'b0;
        o_w_sa_valid    = 1'b0;
        o_w_ta_set_addr = '0;
        o_w_sa_set_addr = '0;
        o_w_ta_data     = '0;
        o_w_sa_data     = '0;
        o_w_ta_mask     = '0;
        o_w_sa_mask     = '0;

        case (state_q)
            ST_SWEEP: begin
                o_w_ta_valid    = 1'b1;
                o_w_sa_valid    = 1'b1;
                o_w_ta_set_addr = sweep_cnt_q;
                o_w_sa_set_addr = sweep_cnt_q;
                o_w_ta_mask     = '1;
                o_w_sa_mask     = '1;
                if (i_s1_ready) begin
                    if (sweep_cnt_q == LAST_SET) begin
                        sweep_cnt_d = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        sweep_cnt_d = sweep_cnt_q + SET_BITS_WIDTH'(1);
                    end
                end
            end
            ST_IDLE: begin
                o_fill_ready = ~flush_pend_q & ~i_flush;
                if (i_flush || flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    state_d      = ST_SWEEP;
                end else if (i_fill_valid) begin
                    fill_accept = 1'b1;
                    state_d     = ST_FILL;
                end else begin
                    o_r_valid    = i_lk_valid & i_s1_ready;
                    o_r_set_addr = i_lk_set_addr;
                    o_lk_ready   = i_s1_ready;
                end
            end
            ST_FILL: begin
                o_w_ta_valid    = 1'b1;
                o_w_sa_valid    = 1'b1;
                o_w_ta_set_addr = fill_set_q;
                o_w_sa_set_addr = fill_set_q;
                o_w_ta_data     = {NUM_WAYS{fill_tag_q}};
                o_w_sa_data     = SA_W'({SA_W{1'b1}});
                o_w_ta_mask     = NUM_WAYS'(1) << fill_way_q;
                o_w_sa_mask     = NUM_WAYS'(1) << fill_way_q;
                if (i_flush) begin
                    flush_pend_d = 1'b1;
                end
                if (i_s1_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_SWEEP;
            end
        endcase

        if (rst) begin
            o_lk_ready   = 1'b0;
            o_fill_ready = 1'b0;
            o_r_valid    = 1'b0;
            o_w_ta_valid = 1'b0;
            o_w_sa_valid = 1'b0;
            o_w_ta_data  = TA_W'(0);
            o_w_ta_mask  = '0;
            o_w_sa_mask  = '0;
        end
    end

    assign o_fill_done = fill_done_q & ~rst;
    assign o_busy      = (state_q == ST_SWEEP) | rst;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: IDLE arbitration table plus
// hand-written sweep, fill, collision, flush and reset sequences.
module tb_icache_fill_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  i_lk_set_addr;
    logic        i_lk_valid;
    logic        o_lk_ready;
    logic [3:0]  i_fill_set_addr;
    logic [1:0]  i_fill_way;
    logic [7:0]  i_fill_tag;
    logic        i_fill_valid;
    logic        o_fill_ready;
    logic        o_fill_done;
    logic        i_flush;
    logic        o_busy;
    logic        i_s1_ready;
    logic [3:0]  o_r_set_addr;
    logic        o_r_valid;
    logic [3:0]  o_w_ta_set_addr;
    logic [31:0] o_w_ta_data;
    logic [3:0]  o_w_ta_mask;
    logic        o_w_ta_valid;
    logic [3:0]  o_w_sa_set_addr;
    logic [7:0]  o_w_sa_data;
    logic [3:0]  o_w_sa_mask;
    logic        o_w_sa_valid;

    int n_cmp;
    int n_fail;

    icache_fill_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .i_lk_set_addr   (i_lk_set_addr),
        .i_lk_valid      (i_lk_valid),
        .o_lk_ready      (o_lk_ready),
        .i_fill_set_addr (i_fill_set_addr),
        .i_fill_way      (i_fill_way),
        .i_fill_tag      (i_fill_tag),
        .i_fill_valid    (i_fill_valid),
        .o_fill_ready    (o_fill_ready),
        .o_fill_done     (o_fill_done),
        .i_flush         (i_flush),
        .o_busy          (o_busy),
        .i_s1_ready      (i_s1_ready),
        .o_r_set_addr    (o_r_set_addr),
        .o_r_valid       (o_r_valid),
        .o_w_ta_set_addr (o_w_ta_set_addr),
        .o_w_ta_data     (o_w_ta_data),
        .o_w_ta_mask     (o_w_ta_mask),
        .o_w_ta_valid    (o_w_ta_valid),
        .o_w_sa_set_addr (o_w_sa_set_addr),
        .o_w_sa_data     (o_w_sa_data),
        .o_w_sa_mask     (o_w_sa_mask),
        .o_w_sa_valid    (o_w_sa_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       fill_v;
        logic       lk_v;
        logic [3:0] lk_set;
        logic       s1r;
        logic       flush;
        logic       e_lk_ready;
        logic       e_r_valid;
        logic [3:0] e_r_set;
        logic       chk_set;
        logic       e_fill_ready;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs from the first SWEEP cycle until o_busy drops, stalling at one set
    task automatic run_sweep(input int stall_set, input int stall_len, input int exp_cycles);
        int cyc;
        int exp_set;
        int stalls;
        cyc     = 0;
        exp_set = 0;
        stalls  = stall_len;
        while (o_busy && cyc < 100) begin
            if (exp_set == stall_set && stalls > 0) begin
                i_s1_ready = 1'b0;
                stalls--;
            end else begin
                i_s1_ready = 1'b1;
            end
            #1;
            check("sweep_ta_set", 64'(o_w_ta_set_addr), 64'(exp_set));
            check("sweep_sa_set", 64'(o_w_sa_set_addr), 64'(exp_set));
            check("sweep_fields",
                  64'({o_w_ta_valid, o_w_sa_valid, o_w_ta_mask, o_w_sa_mask, o_w_ta_data, o_w_sa_data}),
                  64'({1'b1, 1'b1, 4'hF, 4'hF, 32'h0, 8'h0}));
            check("sweep_no_read", 64'({o_r_valid, o_lk_ready, o_fill_ready}), 64'(0));
            cyc++;
            if (i_s1_ready) exp_set++;
            @(negedge clk);
        end
        i_s1_ready = 1'b1;
        check("sweep_cycles", 64'(cyc), 64'(exp_cycles));
        check("busy_after_sweep", 64'(o_busy), 64'(0));
    endtask

    initial begin
        n_cmp           = 0;
        n_fail          = 0;
        rst             = 1'b1;
        i_lk_set_addr   = '0;
        i_lk_valid      = 1'b0;
        i_fill_set_addr = '0;
        i_fill_way      = '0;
        i_fill_tag      = '0;
        i_fill_valid    = 1'b0;
        i_flush         = 1'b0;
        i_s1_ready      = 1'b1;

        //          fill lk  set    s1r  fl   lkr  rv   rset  chk  fr
        vecs[0] = '{1'b0, 1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 1'b1, 4'd3,  1'b1, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 4'd7,  1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 4'd12, 1'b1, 1'b0, 1'b1, 1'b0, 4'd12, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 4'd4,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 4'd2,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1, 4'd15, 1'b1, 1'b1};

        // Reset state
        @(negedge clk);
        #1;
        check("rst_writes", 64'({o_w_ta_valid, o_w_sa_valid, o_w_ta_mask, o_w_sa_mask, o_w_ta_data}), 64'(0));
        check("rst_handshakes", 64'({o_fill_ready, o_lk_ready, o_fill_done, o_r_valid}), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(1));
        rst = 1'b0;

        // Reset sweep
        run_sweep(-1, 0, 16);

        // IDLE arbitration table, combinational only, cleared before each edge
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            i_fill_valid  = vecs[i].fill_v;
            i_lk_valid    = vecs[i].lk_v;
            i_lk_set_addr = vecs[i].lk_set;
            i_s1_ready    = vecs[i].s1r;
            i_flush       = vecs[i].flush;
            #1;
            check("tbl_lk_ready", 64'(o_lk_ready), 64'(vecs[i].e_lk_ready));
            check("tbl_r_valid", 64'(o_r_valid), 64'(vecs[i].e_r_valid));
            check("tbl_fill_ready", 64'(o_fill_ready), 64'(vecs[i].e_fill_ready));
            check("tbl_no_write", 64'({o_w_ta_valid, o_w_sa_valid}), 64'(0));
            if (vecs[i].chk_set) check("tbl_r_set", 64'(o_r_set_addr), 64'(vecs[i].e_r_set));
            i_fill_valid = 1'b0;
            i_lk_valid   = 1'b0;
            i_flush      = 1'b0;
            i_s1_ready   = 1'b1;
        end

        // Stalled sweep via flush from IDLE
        @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        run_sweep(5, 3, 19);

        // Fill: set 9, way 2, tag A5
        i_fill_valid    = 1'b1;
        i_fill_set_addr = 4'd9;
        i_fill_way      = 2'd2;
        i_fill_tag      = 8'hA5;
        #1;
        check("fill_ready", 64'(o_fill_ready), 64'(1));
        @(negedge clk);
        i_fill_valid = 1'b0;
        #1;
        check("fill_ta", 64'({o_w_ta_valid, o_w_ta_set_addr, o_w_ta_mask, o_w_ta_data}),
              64'({1'b1, 4'd9, 4'b0100, 32'hA5A5A5A5}));
        check("fill_sa", 64'({o_w_sa_valid, o_w_sa_set_addr, o_w_sa_mask, o_w_sa_data}),
              64'({1'b1, 4'd9, 4'b0100, 8'hFF}));
        check("fill_done_early", 64'(o_fill_done), 64'(0));
        @(negedge clk);
        #1;
        check("fill_done", 64'(o_fill_done), 64'(1));
        check("fill_idle_no_write", 64'(o_w_ta_valid), 64'(0));
        @(negedge clk);
        #1;
        check("fill_done_once", 64'(o_fill_done), 64'(0));

        // Fill vs lookup collision
        i_fill_valid    = 1'b1;
        i_fill_set_addr = 4'd1;
        i_fill_way      = 2'd0;
        i_fill_tag      = 8'h3C;
        i_lk_valid      = 1'b1;
        i_lk_set_addr   = 4'd6;
        #1;
        check("coll_handshake", 64'({o_fill_ready, o_lk_ready, o_r_valid}), 64'(3'b100));
        @(negedge clk);
        i_fill_valid = 1'b0;
        #1;
        check("coll_fill_write", 64'({o_w_ta_valid, o_w_ta_set_addr, o_w_ta_mask, o_w_ta_data}),
              64'({1'b1, 4'd1, 4'b0001, 32'h3C3C3C3C}));
        check("coll_lk_blocked", 64'({o_lk_ready, o_r_valid}), 64'(0));
        @(negedge clk);
        #1;
        check("coll_lk_after_done", 64'({o_fill_done, o_lk_ready, o_r_valid, o_r_set_addr}),
              64'({1'b1, 1'b1, 1'b1, 4'd6}));
        i_lk_valid = 1'b0;

        // Flush during stalled fill
        @(negedge clk);
        i_fill_valid    = 1'b1;
        i_fill_set_addr = 4'd3;
        i_fill_way      = 2'd1;
        i_fill_tag      = 8'h5A;
        @(negedge clk);
        i_fill_valid = 1'b0;
        i_s1_ready   = 1'b0;
        i_flush      = 1'b1;
        #1;
        check("fl_fill_held", 64'({o_w_ta_valid, o_w_sa_valid, o_w_ta_mask, o_busy}), 64'({1'b1, 1'b1, 4'b0010, 1'b0}));
        @(negedge clk);
        i_flush      = 1'b0;
        i_s1_ready   = 1'b1;
        i_fill_valid = 1'b1;
        #1;
        check("fl_fill_write", 64'({o_w_ta_valid, o_w_ta_set_addr, o_w_ta_data}), 64'({1'b1, 4'd3, 32'h5A5A5A5A}));
        @(negedge clk);
        #1;
        check("fl_done_no_refill", 64'({o_fill_done, o_fill_ready, o_busy}), 64'(3'b100));
        @(negedge clk);
        i_fill_valid = 1'b0;
        check("fl_sweep_started", 64'({o_busy, o_fill_done}), 64'(2'b10));
        run_sweep(-1, 0, 16);

        // Reset during stalled fill
        i_fill_valid    = 1'b1;
        i_fill_set_addr = 4'd8;
        i_fill_way      = 2'd3;
        i_fill_tag      = 8'h77;
        @(negedge clk);
        i_fill_valid = 1'b0;
        i_s1_ready   = 1'b0;
        #1;
        check("rf_stalled", 64'({o_w_ta_valid, o_w_ta_mask}), 64'({1'b1, 4'b1000}));
        @(negedge clk);
        rst        = 1'b1;
        i_s1_ready = 1'b1;
        #1;
        check("rf_no_write", 64'({o_w_ta_valid, o_w_sa_valid, o_fill_done}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rf_no_done", 64'({o_fill_done, o_busy}), 64'(2'b01));
        run_sweep(-1, 0, 16);
        check("rf_no_done_after", 64'(o_fill_done), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Sequences all writes into the stage-1 tag array (TA) and status array (SA), and arbitrates them against lookup reads.
- After reset, and on request, it sweeps every set to invalidate the cache.
- It installs line refills (tag plus valid/used bits) into a single way.
- Lookup reads pass through to stage 1 only when no maintenance or fill write is in progress.

Parameters:
- SET_BITS_WIDTH, 4: set index width; the cache has 2^SET_BITS_WIDTH sets.
- NUM_WAYS, 4: ways per set.
- TAG_WIDTH, 8: tag bits per way; TA word = NUM_WAYS*TAG_WIDTH = 32.
- SA_BITS, 2: status bits per way, {used, valid}; SA word = NUM_WAYS*SA_BITS = 8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_lk_set_addr  in  SET_BITS_WIDTH  lookup set index.
- i_lk_valid  in  1  lookup request.
- o_lk_ready  out  1  lookup accepted this cycle.
- i_fill_set_addr  in  SET_BITS_WIDTH  refill set.
- i_fill_way  in  2  refill way index.
- i_fill_tag  in  TAG_WIDTH  refill tag.
- i_fill_valid  in  1  refill request.
- o_fill_ready  out  1  refill request accepted.
- o_fill_done  out  1  one-cycle pulse when the refill write completes.
- i_flush  in  1  invalidate-all request (level; latched).
- o_busy  out  1  INIT or FLUSH sweep in progress.
- i_s1_ready  in  1  stage-1 ready for reads and writes.
- o_r_set_addr  out  SET_BITS_WIDTH  to stage-1 read address.
- o_r_valid  out  1  to stage-1 read valid.
- o_w_ta_set_addr  out  SET_BITS_WIDTH  TA write set.
- o_w_ta_data  out  32  TA write data.
- o_w_ta_mask  out  NUM_WAYS  TA write way mask.
- o_w_ta_valid  out  1  TA write valid.
- o_w_sa_set_addr  out  SET_BITS_WIDTH  SA write set.
- o_w_sa_data  out  8  SA write data.
- o_w_sa_mask  out  NUM_WAYS  SA write way mask.
- o_w_sa_valid  out  1  SA write valid.

Behaviour:
- Reset (rst high at a clk edge):
  - State becomes SWEEP, sweep counter = 0, flush-pending = 0.
  - All write outputs are 0.
  - o_fill_ready, o_lk_ready, o_fill_done = 0; o_busy = 1.
- Reset asserted mid-sweep or mid-fill aborts the operation; the sweep restarts at set 0.
- States: SWEEP, IDLE, FILL.
- SWEEP:
  - Drives o_w_ta_valid = o_w_sa_valid = 1, set addr = counter, TA data = 0, SA data = 0, both masks = 4'hF.
  - When i_s1_ready = 1, the counter increments.
  - When the counter = 2^SET_BITS_WIDTH-1 and i_s1_ready = 1, the counter wraps to 0 and the state goes to IDLE.
  - The counter holds while i_s1_ready = 0.
  - o_busy = 1 throughout.
  - Sweep length is exactly 16 cycles when i_s1_ready is held high.
- IDLE:
  - o_fill_ready = ~flush-pending & ~i_flush.
  - Priority is flush > fill > lookup.
  - If i_flush or flush-pending: clear flush-pending and go to SWEEP next cycle; no fill is accepted that cycle.
  - Else if i_fill_valid: latch set, way, tag and go to FILL; the lookup is not accepted that cycle (o_lk_ready = 0).
  - Else: o_r_valid = i_lk_valid & i_s1_ready, o_r_set_addr = i_lk_set_addr, o_lk_ready = i_s1_ready. This read path is combinational, zero added latency.
- FILL:
  - TA data = tag replicated across all ways; TA mask = one-hot(way).
  - SA data = 2'b11 replicated; SA mask = one-hot(way).
  - Both write valids = 1 and are held until i_s1_ready = 1.
  - On that cycle: o_fill_done pulses in the next cycle (registered) and the state returns to IDLE.
- i_flush asserted during FILL sets flush-pending. The fill completes first, then the sweep starts.
- i_flush during SWEEP is ignored; the sweep already invalidates everything.
- o_r_valid = 0 and o_lk_ready = 0 in SWEEP and FILL.
- Write valids are 0 in IDLE.
- TA and SA writes for a given operation always occur in the same cycle with the same set address.
- o_busy = (state == SWEEP).

Test Plan:
- Reset sweep:
  - Stimulus: rst 1 cycle, i_s1_ready = 1.
  - Required: 16 consecutive write cycles, sets 0..15, masks 4'hF, data 0.
  - Then o_busy falls and IDLE is entered on cycle 17.
- Stalled sweep:
  - Stimulus: i_s1_ready low for 3 cycles at set 5.
  - Required: set 5 is held for 4 cycles and the total sweep is 19 cycles.
- Fill:
  - Stimulus: i_fill_valid with set 9, way 2, tag 8'hA5.
  - Required: one cycle later, TA data 32'hA5A5A5A5 mask 4'b0100, SA data 8'hFF mask 4'b0100, set 9.
  - Then o_fill_done pulses once.
- Fill vs lookup collision:
  - Stimulus: i_fill_valid and i_lk_valid in the same IDLE cycle.
  - Required: o_fill_ready = 1, o_lk_ready = 0, o_r_valid = 0.
  - The lookup is accepted on the first IDLE cycle after o_fill_done.
- Flush during fill:
  - Stimulus: i_flush pulse while FILL is stalled by i_s1_ready = 0.
  - Required: the fill write completes first, then a full 16-set sweep follows; no second fill is accepted in between.
- Reset mid-fill:
  - Stimulus: rst while FILL is stalled.
  - Required: the fill write is never issued, o_fill_done stays 0, and the sweep restarts at set 0.
